// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Purpose:
//   Instruction prefetch unit with a small FIFO. It streams sequential fetch
//   requests to a synchronous instruction ROM with a fixed one-cycle latency
//   and queues each returned instruction with its address. A consumer drains
//   the queue with a valid/ready handshake. A redirect (taken branch or jump)
//   flushes the queue and the in-flight response, then restarts fetching at
//   redirect_pc on the next cycle.
//
// Ports:
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous active-high reset
//   imem_req     out  1        fetch request this cycle
//   imem_addr    out  PC_W     fetch address (the current fetch PC)
//   imem_rdata   in   INSN_W   instruction for the previous cycle's request
//   redirect     in   1        flush and refetch from redirect_pc
//   redirect_pc  in   PC_W     new fetch address when redirect=1
//   insc_valid   out  1        queue head valid
//   insc         out  INSN_W   queue head instruction
//   pc           out  PC_W     address of the queue head instruction
//   insc_ready   in   1        consumer accepts the head this cycle
//   count        out  CNT_W    number of occupied queue entries
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int              PC_W     = 8,
    parameter int              INSN_W   = 32,
    parameter int              DEPTH    = 4,
    parameter int              PC_STEP  = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INSN_W-1:0]          imem_rdata,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       insc_valid,
    output logic [INSN_W-1:0]          insc,
    output logic [PC_W-1:0]            pc,
    input  logic                       insc_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PC_W-1:0]  STEP      = PC_W'(PC_STEP);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    // The flush lasts exactly as long as redirect is high, so the state is a
    // direct decode of redirect rather than a stored value: the first request
    // after a redirect must go out on the very next cycle.
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e state;

    logic [PC_W-1:0]   fetch_pc_q,    fetch_pc_d;
    logic              inflight_q,    inflight_d;
    logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0]  count_q,       count_d;
    logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;

    // Queue storage holds data only; occupancy is tracked by the pointers and
    // count, so the arrays need no reset.
    logic [INSN_W-1:0] insn_mem_q [DEPTH];
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];

    logic              deq;
    logic              enq;
    logic [CNT_W:0]    occ;

    always_comb begin
        state = redirect ? ST_FLUSH : ST_FETCH;
    end

    assign insc_valid = (count_q != '0);
    assign deq        = insc_valid && insc_ready;

    // A returning response is written unless a redirect kills it this cycle.
    assign enq        = inflight_q && (state == ST_FETCH);

    // Entries that will be occupied once the outstanding response lands,
    // after the head leaves. Requesting only while this is below DEPTH means
    // every response always has a free slot to land in.
    assign occ        = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(deq);

    assign imem_req   = !rst && (state == ST_FETCH) && (occ < DEPTH_OCC);
    assign imem_addr  = fetch_pc_q;
    assign count      = count_q;

    // Empty queue drives defined values so outputs are clean during reset.
    assign insc       = insc_valid ? insn_mem_q[rd_ptr_q] : '0;
    assign pc         = insc_valid ? pc_mem_q[rd_ptr_q]   : RESET_PC;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = fetch_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (state == ST_FLUSH) begin
            // The head transfer in this cycle (if any) completes at the
            // consumer; everything else is discarded.
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (imem_req) begin
                // Wraps modulo 2^PC_W by construction.
                fetch_pc_d = fetch_pc_q + STEP;
            end
            rd_ptr_d = rd_ptr_q + PTR_W'(deq);
            wr_ptr_d = wr_ptr_q + PTR_W'(enq);
            count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            insn_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    // ------------------------------------------------------------------
    // Main instance: defaults (PC_W=8, INSN_W=32, DEPTH=4, PC_STEP=4)
    // ------------------------------------------------------------------
    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        insc_valid;
    logic [31:0] insc;
    logic [7:0]  pc;
    logic        insc_ready;
    logic [2:0]  count;

    inst_fetch_queue u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .insc_valid  (insc_valid),
        .insc        (insc),
        .pc          (pc),
        .insc_ready  (insc_ready),
        .count       (count)
    );

    // ------------------------------------------------------------------
    // Second instance: DEPTH=2, PC_STEP=1
    // ------------------------------------------------------------------
    logic        rst2;
    logic        imem_req2;
    logic [7:0]  imem_addr2;
    logic [31:0] imem_rdata2;
    logic        redirect2;
    logic [7:0]  redirect_pc2;
    logic        insc_valid2;
    logic [31:0] insc2;
    logic [7:0]  pc2;
    logic        insc_ready2;
    logic [1:0]  count2;

    inst_fetch_queue #(
        .PC_W    (8),
        .INSN_W  (32),
        .DEPTH   (2),
        .PC_STEP (1),
        .RESET_PC(8'h00)
    ) u_dut2 (
        .clk         (clk),
        .rst         (rst2),
        .imem_req    (imem_req2),
        .imem_addr   (imem_addr2),
        .imem_rdata  (imem_rdata2),
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2),
        .insc_valid  (insc_valid2),
        .insc        (insc2),
        .pc          (pc2),
        .insc_ready  (insc_ready2),
        .count       (count2)
    );

    // Synchronous ROM models with ROM[a] = a, latency 1.
    always @(posedge clk) begin
        imem_rdata  <= {24'h0, imem_addr};
        imem_rdata2 <= {24'h0, imem_addr2};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    logic [7:0]  got_pc[$];
    logic [31:0] got_insn[$];
    logic [7:0]  got_pc2[$];
    logic [31:0] got_insn2[$];

    // Transfers are recorded mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (!rst && insc_valid && insc_ready) begin
            got_pc.push_back(pc);
            got_insn.push_back(insc);
        end
        if (!rst2 && insc_valid2 && insc_ready2) begin
            got_pc2.push_back(pc2);
            got_insn2.push_back(insc2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 40 && got_pc.size() < n; i++) step();
        checks++;
        if (got_pc.size() < n) begin
            failures++;
            $display("FAIL wait_got timeout: got %0d transfers, required %0d", got_pc.size(), n);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst         = 1'b1;
        rst2        = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        insc_ready  = 1'b1;
        redirect2   = 1'b0;
        redirect_pc2 = 8'h00;
        insc_ready2 = 1'b0;
        repeat (5) step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b, required 0", imem_req); end
        checks++; if (insc_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", insc_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d, required 0", count); end
        checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc: got %h, required 00", pc); end
        checks++; if (insc !== 32'h0) begin failures++; $display("FAIL reset_insc: got %h, required 0", insc); end
        checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr: got %h, required 00", imem_addr); end
    endtask

    // Release reset with consumer ready: requests 0,4,8; valid at cycle 2.
    task automatic test_stream();
        rst        = 1'b0;
        insc_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin failures++; $display("FAIL stream_c0: req=%b addr=%h, required req=1 addr=00", imem_req, imem_addr); end
        step();
        checks++; if (insc_valid !== 1'b0) begin failures++; $display("FAIL stream_c1_valid: got %b, required 0", insc_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin failures++; $display("FAIL stream_c1: req=%b addr=%h, required req=1 addr=04", imem_req, imem_addr); end
        step();
        checks++; if (insc_valid !== 1'b1 || pc !== 8'h00 || insc !== 32'h00) begin failures++; $display("FAIL stream_c2: valid=%b pc=%h insc=%h, required 1/00/00", insc_valid, pc, insc); end
        step();
        checks++; if (insc_valid !== 1'b1 || pc !== 8'h04 || insc !== 32'h04) begin failures++; $display("FAIL stream_c3: valid=%b pc=%h insc=%h, required 1/04/04", insc_valid, pc, insc); end
        step();
        checks++; if (insc_valid !== 1'b1 || pc !== 8'h08 || insc !== 32'h08) begin failures++; $display("FAIL stream_c4: valid=%b pc=%h insc=%h, required 1/08/08", insc_valid, pc, insc); end
    endtask

    // Stall the consumer for 10 cycles: queue fills to 4, fetching stops,
    // then the stream resumes gap-free.
    task automatic test_backpressure();
        rst        = 1'b1;
        insc_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        got_pc.delete(); got_insn.delete();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (count > 3'd4) begin failures++; $display("FAIL bp_overflow: count=%0d, required <=4", count); end
        end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL bp_count: got %0d, required 4", count); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req: got %b, required 0", imem_req); end
        checks++; if (insc_valid !== 1'b1 || pc !== 8'h00 || insc !== 32'h0) begin failures++; $display("FAIL bp_head_hold: valid=%b pc=%h insc=%h, required 1/00/00", insc_valid, pc, insc); end
        insc_ready = 1'b1;
        wait_got(5);
        for (int k = 0; k < 5; k++) begin
            logic [7:0] exp_pc;
            exp_pc = 8'(k * 4);
            checks++;
            if (k >= got_pc.size() || got_pc[k] !== exp_pc || got_insn[k] !== {24'h0, exp_pc}) begin
                failures++;
                $display("FAIL bp_order[%0d]: got pc=%h insc=%h, required %h", k,
                         (k < got_pc.size()) ? got_pc[k] : 8'hxx,
                         (k < got_insn.size()) ? got_insn[k] : 32'hx, exp_pc);
            end
        end
    endtask

    // Redirect with 3 queued and one in flight: only the new stream appears.
    task automatic test_redirect();
        rst        = 1'b1;
        insc_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        repeat (4) step();
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL redir_pre_count: got %0d, required 3", count); end
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req: got %b, required 0", imem_req); end
        step();
        redirect = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || insc_valid !== 1'b0) begin failures++; $display("FAIL redir_flush: count=%0d valid=%b, required 0/0", count, insc_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin failures++; $display("FAIL redir_first_req: req=%b addr=%h, required 1/40", imem_req, imem_addr); end
        got_pc.delete(); got_insn.delete();
        insc_ready = 1'b1;
        wait_got(3);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] exp_pc;
            exp_pc = 8'(8'h40 + k * 4);
            checks++;
            if (k >= got_pc.size() || got_pc[k] !== exp_pc || got_insn[k] !== {24'h0, exp_pc}) begin
                failures++;
                $display("FAIL redir_order[%0d]: got pc=%h, required %h", k,
                         (k < got_pc.size()) ? got_pc[k] : 8'hxx, exp_pc);
            end
        end
    endtask

    // PC wraps from 0xFC to 0x00.
    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 8'hF8;
        step();
        redirect = 1'b0;
        got_pc.delete(); got_insn.delete();
        #1;
        checks++; if (imem_addr !== 8'hF8) begin failures++; $display("FAIL wrap_addr0: got %h, required F8", imem_addr); end
        step();
        checks++; if (imem_addr !== 8'hFC) begin failures++; $display("FAIL wrap_addr1: got %h, required FC", imem_addr); end
        step();
        checks++; if (imem_addr !== 8'h00 || imem_req !== 1'b1) begin failures++; $display("FAIL wrap_addr2: addr=%h req=%b, required 00/1", imem_addr, imem_req); end
        wait_got(3);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] exp_pc;
            exp_pc = 8'(8'hF8 + k * 4);
            checks++;
            if (k >= got_pc.size() || got_pc[k] !== exp_pc || got_insn[k] !== {24'h0, exp_pc}) begin
                failures++;
                $display("FAIL wrap_order[%0d]: got pc=%h, required %h", k,
                         (k < got_pc.size()) ? got_pc[k] : 8'hxx, exp_pc);
            end
        end
    endtask

    // Head transfer completes in the redirect cycle; two consecutive
    // redirects, the last one wins.
    task automatic test_back_to_back();
        rst        = 1'b1;
        insc_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        repeat (4) step();
        got_pc.delete(); got_insn.delete();
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        step();
        redirect_pc = 8'h20;
        step();
        redirect = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h20) begin failures++; $display("FAIL b2b_req: req=%b addr=%h, required 1/20", imem_req, imem_addr); end
        wait_got(4);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_pc;
            exp_pc = (k == 0) ? 8'h08 : 8'(8'h20 + (k - 1) * 4);
            checks++;
            if (k >= got_pc.size() || got_pc[k] !== exp_pc || got_insn[k] !== {24'h0, exp_pc}) begin
                failures++;
                $display("FAIL b2b_order[%0d]: got pc=%h, required %h", k,
                         (k < got_pc.size()) ? got_pc[k] : 8'hxx, exp_pc);
            end
        end
    endtask

    // One-cycle reset pulse with a full queue clears it immediately.
    task automatic test_reset_full();
        rst        = 1'b1;
        insc_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        repeat (8) step();
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL rstf_pre_count: got %0d, required 4", count); end
        rst = 1'b1;
        #1;
        checks++; if (insc_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL rstf_immediate: valid=%b count=%0d, required 0/0", insc_valid, count); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstf_req: got %b, required 0", imem_req); end
        step();
        rst        = 1'b0;
        insc_ready = 1'b1;
        got_pc.delete(); got_insn.delete();
        #1;
        checks++; if (imem_addr !== 8'h00 || imem_req !== 1'b1) begin failures++; $display("FAIL rstf_first_req: addr=%h req=%b, required 00/1", imem_addr, imem_req); end
        wait_got(1);
        checks++;
        if (got_pc.size() < 1 || got_pc[0] !== 8'h00) begin
            failures++;
            $display("FAIL rstf_first_pc: got %h, required 00", (got_pc.size() > 0) ? got_pc[0] : 8'hxx);
        end
    endtask

    // DEPTH=2, PC_STEP=1, consumer ready toggling every cycle.
    task automatic test_depth2();
        rst2        = 1'b1;
        insc_ready2 = 1'b0;
        step(); step();
        rst2 = 1'b0;
        got_pc2.delete(); got_insn2.delete();
        for (int i = 0; i < 60; i++) begin
            insc_ready2 = ~insc_ready2;
            step();
            checks++; if (count2 > 2'd2) begin failures++; $display("FAIL d2_overflow: count=%0d, required <=2", count2); end
        end
        checks++;
        if (got_pc2.size() < 20) begin
            failures++;
            $display("FAIL d2_delivered: got %0d transfers, required >=20", got_pc2.size());
        end
        for (int k = 0; k < got_pc2.size(); k++) begin
            checks++;
            if (got_pc2[k] !== 8'(k) || got_insn2[k] !== {24'h0, 8'(k)}) begin
                failures++;
                $display("FAIL d2_order[%0d]: got pc=%h insc=%h, required %h", k, got_pc2[k], got_insn2[k], 8'(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_reset_full();
        test_depth2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
